alu_mc: RTL and testbench



---
 rtl/alu_mc.sv | 201 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) complete at the accepting edge;
// MULU (shift-add) and, when ALU_MC_DIV_EN is defined, DIVU/REMU (restoring
// divide) take exactly WIDTH clocks behind a start/busy/done handshake.
// Without ALU_MC_DIV_EN the divider is not built and 1001/1010 behave as ADD.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; single-cycle ops complete from here
// MUL   | shift-add multiply, one multiplier bit per clock
// DIV   | restoring divide, one quotient bit per clock

module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    // op_a: multiplicand (shifts left) or dividend/quotient (shifts left)
    // op_b: multiplier (shifts right) or divisor (static)
    // acc:  partial product or partial remainder
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;

    logic             is_mul;
    logic             is_div;
    logic             last_iter;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_acc_nxt;

    assign is_mul    = (ctrl_i == OP_MULU);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy_o    = (state != IDLE);
    assign zero_o    = (result_o == '0);

`ifdef ALU_MC_DIV_EN
    logic             op_rem;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign is_div = (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);

    // One restoring-divide step; a zero divisor never borrows, which yields
    // an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        rem_shift = {acc, op_a[WIDTH-1]};
        div_ok    = (rem_shift >= {1'b0, op_b});
        div_diff  = rem_shift[WIDTH-1:0] - op_b;
        rem_nxt   = div_ok ? div_diff : rem_shift[WIDTH-1:0];
        quo_nxt   = {op_a[WIDTH-2:0], div_ok};
    end
`else
    assign is_div = 1'b0;
`endif

    // Single-cycle result from the live operands; unknown codes add.
    always_comb begin
        alu_res = src1_i + src2_i;
        case (ctrl_i)
            OP_AND: alu_res = src1_i & src2_i;
            OP_OR:  alu_res = src1_i | src2_i;
            OP_SUB: alu_res = src1_i - src2_i;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_NOR: alu_res = ~(src1_i | src2_i);
            default: alu_res = src1_i + src2_i;
        endcase
    end

    // One shift-add multiply step.
    assign mul_acc_nxt = acc + (op_b[0] ? op_a : '0);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: iterative ops leave IDLE, return after WIDTH steps.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (is_mul) begin
                        state_nxt = MUL;
                    end else if (is_div) begin
                        state_nxt = DIV;
                    end
                end
            end
            MUL: begin
                if (last_iter) begin
                    state_nxt = IDLE;
                end
            end
`ifdef ALU_MC_DIV_EN
            DIV: begin
                if (last_iter) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, iteration counter and result/done registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
`ifdef ALU_MC_DIV_EN
            op_rem   <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (is_mul || is_div) begin
                            op_a <= src1_i;
                            op_b <= src2_i;
                            acc  <= '0;
                            cnt  <= '0;
`ifdef ALU_MC_DIV_EN
                            op_rem <= (ctrl_i == OP_REMU);
`endif
                        end else begin
                            result_o <= alu_res;
                            done_o   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc  <= mul_acc_nxt;
                    op_a <= op_a << 1;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        result_o <= mul_acc_nxt;
                        done_o   <= 1'b1;
                    end
                end
`ifdef ALU_MC_DIV_EN
                DIV: begin
                    acc  <= rem_nxt;
                    op_a <= quo_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        result_o <= op_rem ? rem_nxt : quo_nxt;
                        done_o   <= 1'b1;
                    end
                end
`endif
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases followed by random ops,
// compared against an arithmetic reference model.

module tb_alu_mc;

    localparam int W = 32;
`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ctrl;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .src1_i   (src1),
        .src2_i   (src2),
        .ctrl_i   (ctrl),
        .result_o (result),
        .zero_o   (zero),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1100: return ~(a | b);
            4'b1000: return a * b;
            4'b1001: begin
                if (!DIV_EN) return a + b;
                return (b == 0) ? '1 : a / b;
            end
            4'b1010: begin
                if (!DIV_EN) return a + b;
                return (b == 0) ? a : a % b;
            end
            default: return a + b;
        endcase
    endfunction

    function automatic bit is_iter(input logic [3:0] op);
        return (op == 4'b1000) || (DIV_EN && (op == 4'b1001 || op == 4'b1010));
    endfunction

    // Issue one op and follow it to completion, scrambling inputs while busy.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold_start);
        logic [W-1:0] exp;
        exp = ref_result(op, a, b);
        @(negedge clk);
        start = 1'b1;
        ctrl  = op;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (is_iter(op)) begin
            for (int i = 0; i < W; i++) begin
                check("busy_during", W'(busy), W'(1));
                check("done_during", W'(done), W'(0));
                check("result_hold", result, last_res);
                src1  = $urandom;
                src2  = $urandom;
                ctrl  = 4'($urandom);
                start = hold_start | 1'($urandom);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        check("done", W'(done), W'(1));
        check("busy_end", W'(busy), W'(0));
        check("result", result, exp);
        check("zero", W'(zero), W'(exp == 0));
        last_res = exp;
    endtask

    // One cycle with no request: done must drop and the result must hold.
    task automatic idle_check();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", W'(done), W'(0));
        check("idle_busy", W'(busy), W'(0));
        check("idle_result", result, last_res);
    endtask

    task automatic reset_mid_mul();
        @(negedge clk);
        start = 1'b1;
        ctrl  = 4'b1000;
        src1  = $urandom;
        src2  = $urandom | 32'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("rst_pre_busy", W'(busy), W'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_res = '0;
        check("rst_result", result, '0);
        check("rst_zero", W'(zero), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        repeat (W) begin
            @(posedge clk);
            #1;
            check("rst_no_done", W'(done), W'(0));
        end
        check("rst_result_hold", result, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst   = 1'b1;
        start = 1'b0;
        src1  = '0;
        src2  = '0;
        ctrl  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, '0);
        check("reset_zero", W'(zero), W'(1));
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        rst = 1'b0;

        run_op(4'b0010, 32'd7, 32'd5, 1'b0);
        run_op(4'b0110, 32'd5, 32'd5, 1'b0);
        idle_check();
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(4'b0111, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run_op(4'b1100, 32'h0F0F_0000, 32'h00F0_F0F0, 1'b0);
        run_op(4'b1000, 32'h0001_0000, 32'h0001_0003, 1'b1);
        idle_check();
        run_op(4'b1001, 32'd100, 32'd7, 1'b0);
        run_op(4'b1010, 32'd100, 32'd7, 1'b0);
        run_op(4'b1001, 32'd9, 32'd0, 1'b0);
        run_op(4'b1010, 32'd9, 32'd0, 1'b0);
        idle_check();

        reset_mid_mul();
        run_op(4'b0010, 32'd1, 32'd1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 50));
                default: b = $urandom;
            endcase
            run_op(op, a, b, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
